// File: rtl/interp_pass_sequencer.sv
// Line-command sequencer for the FIR_A/B/C interpolation bank: one horizontal pass, then four vertical passes.
// Optional macro INTERP_SEQ_ABORT_EN adds an abort input that drops the in-flight block.
module interp_pass_sequencer #(
  parameter int NUM_PIXEL = 8,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef INTERP_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_dir,
  output logic [1:0]       cmd_src,
  output logic [IDX_W-1:0] cmd_idx,
  output logic             cmd_last,
  output logic             fb_we,
  output logic             out_we,
  output logic [7:0]       blk_cnt
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_HPASS | row commands 0..N+6 from the input buffer, fills A/B/C
  // S_VP_I  | column commands 0..N-1, integer source
  // S_VP_A  | column commands 0..N-1, A buffer source
  // S_VP_B  | column commands 0..N-1, B buffer source
  // S_VP_C  | column commands 0..N-1, C buffer source
  // S_DONE  | one-cycle completion, block counter bumps on exit
  typedef enum logic [2:0] {
    S_IDLE, S_HPASS, S_VP_I, S_VP_A, S_VP_B, S_VP_C, S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] H_LAST = IDX_W'(NUM_PIXEL + 6);
  localparam logic [IDX_W-1:0] V_LAST = IDX_W'(NUM_PIXEL - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       blk_cnt_q, blk_cnt_d;
  logic             pass_active, is_hpass, abort_hit, accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    blk_cnt_d = blk_cnt_q;
`ifdef INTERP_SEQ_ABORT_EN
    abort_hit = abort && (state_q != S_IDLE);
`else
    abort_hit = 1'b0;
`endif
    is_hpass    = (state_q == S_HPASS);
    pass_active = (state_q == S_HPASS) || (state_q == S_VP_I) || (state_q == S_VP_A) ||
                  (state_q == S_VP_B)  || (state_q == S_VP_C);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE) && !abort_hit;
    cmd_valid = pass_active && !abort_hit;
    cmd_dir   = pass_active && !is_hpass;
    cmd_idx   = idx_q;
    cmd_last  = pass_active && (idx_q == (is_hpass ? H_LAST : V_LAST));
    accept    = cmd_valid && cmd_ready;
    fb_we     = accept && is_hpass;
    out_we    = accept && !is_hpass;
    blk_cnt   = blk_cnt_q;
    case (state_q)
      S_VP_A:  cmd_src = 2'd1;
      S_VP_B:  cmd_src = 2'd2;
      S_VP_C:  cmd_src = 2'd3;
      default: cmd_src = 2'd0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HPASS;
          idx_d   = '0;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        blk_cnt_d = blk_cnt_q + 8'd1;
      end
      default: begin
        if (accept) begin
          if (cmd_last) begin
            idx_d = '0;
            case (state_q)
              S_HPASS: state_d = S_VP_I;
              S_VP_I:  state_d = S_VP_A;
              S_VP_A:  state_d = S_VP_B;
              S_VP_B:  state_d = S_VP_C;
              default: state_d = S_DONE;
            endcase
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase

    // Abort discards the block outright: no DONE, counter untouched.
    if (abort_hit) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      blk_cnt_d = blk_cnt_q;
    end
  end

endmodule
